// File: rtl/seq_stream_tx_if.sv
// seq_stream_tx_if: load handshake and serial output bundle for seq_stream_tx.
//   load_valid/load_ready : load handshake (accept on valid & ready)
//   load_data/len/rep     : pattern, bit count, extra repeats
//   outs/out_valid/done   : serial bit, bit-valid qualifier, end-of-frame pulse
// master = pattern source / stream consumer, slave = transmitter.
interface seq_stream_tx_if #(
  parameter int WIDTH = 8,
  parameter int REP_W = 4
);
  localparam int LEN_W = $clog2(WIDTH) + 1;

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic [LEN_W-1:0] load_len;
  logic [REP_W-1:0] load_rep;
  logic             outs;
  logic             out_valid;
  logic             done;

  modport master (
    output load_valid, load_data, load_len, load_rep,
    input  load_ready, outs, out_valid, done
  );

  modport slave (
    input  load_valid, load_data, load_len, load_rep,
    output load_ready, outs, out_valid, done
  );
endinterface

// File: rtl/seq_stream_tx.sv
// seq_stream_tx: serial pattern transmitter, MSB-first, with optional repeats
// and a fixed idle gap between repeats.
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   abort    : synchronous cancel while busy
//   busy     : state != IDLE
//   bus      : load handshake + serial stream (seq_stream_tx_if.slave)
// outs/out_valid/done are registered; load_ready/busy decode the state.
module seq_stream_tx #(
  parameter int WIDTH    = 8,
  parameter int REP_W    = 4,
  parameter int IDLE_GAP = 0
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           abort,
  output logic           busy,
  seq_stream_tx_if.slave bus
);
  localparam int LEN_W = $clog2(WIDTH) + 1;
  localparam int GAP_W = (IDLE_GAP > 0) ? $clog2(IDLE_GAP + 1) : 1;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] bitcnt_q, bitcnt_d;  // bits left, including the one on outs
  logic [REP_W-1:0] rep_q, rep_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             outs_q, outs_d;
  logic             vld_q, vld_d;
  logic             done_q, done_d;

  logic [LEN_W-1:0] len_clamp;
  logic [WIDTH-1:0] pat_in;

  assign len_clamp = (bus.load_len == '0 || bus.load_len > LEN_MAX) ? LEN_MAX : bus.load_len;
  // Left-align so the first bit to send always sits at the MSB.
  assign pat_in    = bus.load_data << (LEN_MAX - len_clamp);

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    pat_d    = pat_q;
    len_d    = len_q;
    bitcnt_d = bitcnt_q;
    rep_d    = rep_q;
    gap_d    = gap_q;
    outs_d   = 1'b0;
    vld_d    = 1'b0;
    done_d   = 1'b0;
    // The registered outputs describe the NEXT cycle, so done is raised on
    // the edge that puts the final bit of the final repeat onto outs.
    unique case (state_q)
      IDLE: begin
        if (bus.load_valid) begin
          pat_d    = pat_in;
          len_d    = len_clamp;
          rep_d    = bus.load_rep;
          state_d  = SHIFT;
          outs_d   = pat_in[WIDTH-1];
          shreg_d  = pat_in << 1;
          vld_d    = 1'b1;
          bitcnt_d = len_clamp;
          done_d   = (len_clamp == LEN_W'(1)) && (bus.load_rep == '0);
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (bitcnt_q == LEN_W'(1)) begin
          if (rep_q == '0) begin
            state_d = IDLE;
          end else begin
            rep_d = rep_q - REP_W'(1);
            if (IDLE_GAP > 0) begin
              state_d = GAP;
              gap_d   = GAP_W'(IDLE_GAP);
              shreg_d = pat_q;
            end else begin
              // no bubble: first bit of the repeat follows immediately
              outs_d   = pat_q[WIDTH-1];
              shreg_d  = pat_q << 1;
              vld_d    = 1'b1;
              bitcnt_d = len_q;
              done_d   = (len_q == LEN_W'(1)) && (rep_q == REP_W'(1));
            end
          end
        end else begin
          outs_d   = shreg_q[WIDTH-1];
          shreg_d  = shreg_q << 1;
          vld_d    = 1'b1;
          bitcnt_d = bitcnt_q - LEN_W'(1);
          done_d   = (bitcnt_q == LEN_W'(2)) && (rep_q == '0);
        end
      end
      GAP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (gap_q == GAP_W'(1)) begin
          state_d  = SHIFT;
          outs_d   = shreg_q[WIDTH-1];
          shreg_d  = shreg_q << 1;
          vld_d    = 1'b1;
          bitcnt_d = len_q;
          done_d   = (len_q == LEN_W'(1)) && (rep_q == '0);
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      pat_q    <= '0;
      len_q    <= '0;
      bitcnt_q <= '0;
      rep_q    <= '0;
      gap_q    <= '0;
      outs_q   <= 1'b0;
      vld_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      pat_q    <= pat_d;
      len_q    <= len_d;
      bitcnt_q <= bitcnt_d;
      rep_q    <= rep_d;
      gap_q    <= gap_d;
      outs_q   <= outs_d;
      vld_q    <= vld_d;
      done_q   <= done_d;
    end
  end

  assign bus.outs       = outs_q;
  assign bus.out_valid  = vld_q;
  // abort during the final-bit cycle still shows the bit but cancels done
  assign bus.done       = done_q & ~abort;
  assign bus.load_ready = (state_q == IDLE);
  assign busy           = (state_q != IDLE);
endmodule

// File: tb/tb_seq_stream_tx.sv
// tb_seq_stream_tx: scoreboard bench for seq_stream_tx. Two instances share
// clk/reset_n/abort: u0 with IDLE_GAP=0, u1 with IDLE_GAP=2; sel picks the
// active one. Expected per-cycle {outs,out_valid,done,busy,load_ready} are
// queued at accept time and popped on each falling edge.
module tb_seq_stream_tx;
  localparam int W  = 8;
  localparam int RW = 4;
  localparam int LW = $clog2(W) + 1;

  logic clk = 1'b0, reset_n = 1'b0, abort = 1'b0;
  always #5 clk = ~clk;

  logic          lv = 1'b0;
  logic [W-1:0]  ld = '0;
  logic [LW-1:0] ll = '0;
  logic [RW-1:0] lr = '0;
  int            sel = 0;
  logic          busy0, busy1;

  seq_stream_tx_if #(.WIDTH(W), .REP_W(RW)) if0 ();
  seq_stream_tx_if #(.WIDTH(W), .REP_W(RW)) if1 ();

  assign if0.load_valid = lv && (sel == 0);
  assign if0.load_data  = ld;
  assign if0.load_len   = ll;
  assign if0.load_rep   = lr;
  assign if1.load_valid = lv && (sel == 1);
  assign if1.load_data  = ld;
  assign if1.load_len   = ll;
  assign if1.load_rep   = lr;

  seq_stream_tx #(.WIDTH(W), .REP_W(RW), .IDLE_GAP(0)) u0 (
    .clk(clk), .reset_n(reset_n), .abort(abort), .busy(busy0), .bus(if0.slave));
  seq_stream_tx #(.WIDTH(W), .REP_W(RW), .IDLE_GAP(2)) u1 (
    .clk(clk), .reset_n(reset_n), .abort(abort), .busy(busy1), .bus(if1.slave));

  logic [4:0] obs;
  assign obs = (sel == 0) ? {if0.outs, if0.out_valid, if0.done, busy0, if0.load_ready}
                          : {if1.outs, if1.out_valid, if1.done, busy1, if1.load_ready};

  logic [4:0] exp_q[$];
  int n_chk = 0, n_pass = 0;
  logic [3:0] det = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
  endtask

  function automatic void push(input logic b, input logic v, input logic dn, input logic bs);
    exp_q.push_back({b, v, dn, bs, ~bs});
  endfunction

  // Stream monitor: one comparison per expected cycle; also feeds a 4-bit
  // window of valid bits, as a sequence detector would see them.
  always @(negedge clk) begin
    logic [4:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("stream {outs,vld,done,busy,rdy}", {27'd0, obs}, {27'd0, e});
      if (obs[3]) det <= {det[2:0], obs[4]};
    end
  end

  // Expected frame: bits MSB-first of the clamped field, gaps between repeats,
  // then one idle cycle.
  task automatic model(input logic [W-1:0] d, input int len, input int rep, input int gap);
    int el;
    el = (len == 0 || len > W) ? W : len;
    for (int r = 0; r <= rep; r++) begin
      for (int i = el - 1; i >= 0; i--) push(d[i], 1'b1, (r == rep) && (i == 0), 1'b1);
      if (r < rep) for (int g = 0; g < gap; g++) push(1'b0, 1'b0, 1'b0, 1'b1);
    end
    push(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Returns 1 time unit after the accepting edge.
  task automatic start(input logic [W-1:0] d, input int len, input int rep);
    @(posedge clk); #1;
    ld = d; ll = LW'(len); lr = RW'(rep); lv = 1'b1;
    chk("ready_before_load", {31'd0, obs[0]}, 32'd1);
    @(posedge clk); #1;
    lv = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk("drain_timeout", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic send(input int s, input logic [W-1:0] d, input int len, input int rep);
    sel = s;
    start(d, len, rep);
    model(d, len, rep, (s == 1) ? 2 : 0);
    drain();
  endtask

  initial begin
    // reset state
    #12;
    chk("reset_u0", {27'd0, if0.outs, if0.out_valid, if0.done, busy0, if0.load_ready}, 32'h1);
    chk("reset_u1", {27'd0, if1.outs, if1.out_valid, if1.done, busy1, if1.load_ready}, 32'h1);
    reset_n = 1'b1;

    // basic send, then detector window
    send(0, 8'h0B, 4, 0);
    chk("detector_1011", {28'd0, det}, 32'hB);

    // length clamp
    send(0, 8'hA5, 0, 0);
    send(0, 8'hA5, 9, 0);
    // back-to-back repeats, single bit
    send(0, 8'h01, 1, 1);
    // maximal repeat count: 16 sends of 101
    send(0, 8'h05, 3, 15);
    send(0, 8'h5A, 8, 0);

    // repeats with IDLE_GAP=2
    send(1, 8'h0B, 4, 2);
    send(1, 8'h01, 1, 0);
    send(1, 8'h01, 1, 1);
    send(1, 8'h96, 8, 1);

    // busy load ignored, then abort after bit 2
    sel = 0;
    start(8'hB5, 8, 0);
    push(1'b1, 1'b1, 1'b0, 1'b1);
    push(1'b0, 1'b1, 1'b0, 1'b1);
    push(1'b0, 1'b0, 1'b0, 1'b0);
    push(1'b0, 1'b0, 1'b0, 1'b0);
    chk("ready_while_busy", {31'd0, if0.load_ready}, 32'd0);
    ld = 8'h00; lv = 1'b1;
    @(posedge clk); #1;
    lv = 1'b0; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    drain();

    // abort on the final-bit cycle: bit shown, done suppressed
    start(8'h02, 2, 0);
    push(1'b1, 1'b1, 1'b0, 1'b1);
    push(1'b0, 1'b1, 1'b0, 1'b1);
    push(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    drain();

    // abort in IDLE together with load: load accepted
    @(posedge clk); #1;
    abort = 1'b1; ld = 8'h03; ll = LW'(2); lr = '0; lv = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; lv = 1'b0;
    model(8'h03, 2, 0, 0);
    drain();

    // async reset mid-SHIFT
    start(8'hFF, 8, 0);
    push(1'b1, 1'b1, 1'b0, 1'b1);
    push(1'b1, 1'b1, 1'b0, 1'b1);
    push(1'b1, 1'b1, 1'b0, 1'b1);
    @(posedge clk); @(posedge clk); @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_outs", {31'd0, if0.outs}, 32'd0);
    chk("async_rst_vld", {31'd0, if0.out_valid}, 32'd0);
    chk("async_rst_busy", {31'd0, busy0}, 32'd0);
    chk("async_rst_rdy", {31'd0, if0.load_ready}, 32'd1);
    chk("async_rst_queue", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    send(0, 8'h0B, 4, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/seq_stream_tx.md
Name: seq_stream_tx

Overview:
- Serial pattern transmitter. Accepts a parallel word over a valid/ready load handshake and shifts it out one bit per clock, MSB-first.
- Supports an optional repeat count and a fixed idle gap between repeats.
- Its output is the serial stimulus/source stream consumed by the team's serial sequence-detector FSMs, whose `ins` input takes `outs` directly.

Parameters:
- WIDTH, 8, maximum pattern length in bits (>=2).
- REP_W, 4, width of the repeat-count field.
- IDLE_GAP, 0, number of low/invalid cycles inserted between repeats (0 = back-to-back).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- load_valid  in  1  load request.
- load_ready  out  1  high only in IDLE; load accepted on an edge where load_valid & load_ready.
- load_data  in  WIDTH  pattern; the len-bit field is load_data[len-1:0].
- load_len  in  $clog2(WIDTH)+1  number of bits to send; 0 or >WIDTH is treated as WIDTH.
- load_rep  in  REP_W  extra repeats (0 = send once).
- abort  in  1  synchronous cancel.
- outs  out  1  serial bit; 0 whenever out_valid=0.
- out_valid  out  1  outs carries a pattern bit this cycle.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse coincident with the final bit of the final repeat.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - outs=0, out_valid=0, done=0, busy=0, load_ready=1.
  - Shift register, bit counter and repeat counter all cleared.
  - Reset mid-frame truncates immediately. No done pulse.
- All outputs are registered, except load_ready and busy, which are decoded from state.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - Accept on load_valid & load_ready.
  - Latch pat = load_data left-aligned (load_data << (WIDTH-len)).
  - Latch len (after the 0/>WIDTH clamp) and rep = load_rep.
  - Next state SHIFT.
  - First bit appears on outs in the cycle after the accepting edge, i.e. latency 1 cycle.
- SHIFT:
  - Each cycle: out_valid=1, outs = shreg[WIDTH-1]; shreg shifts left by 1; bitcnt decrements.
  - Bits go out in order load_data[len-1] down to load_data[0].
- Last bit (bitcnt==1):
  - If rep==0: done=1 this cycle, next state IDLE.
  - Else: rep decrements and shreg reloads from pat. Next state is GAP if IDLE_GAP>0, otherwise SHIFT (first bit of the repeat follows with no bubble).
- GAP:
  - outs=0, out_valid=0 for exactly IDLE_GAP cycles, then SHIFT.
- Frame length in cycles: (load_rep+1)*len + load_rep*IDLE_GAP.
- load_valid while busy: ignored (load_ready=0). No queuing.
- Minimum spacing between frames: one IDLE cycle after done, so the earliest next accept is the edge ending the cycle after done.
- abort:
  - Sampled at any edge while busy: next state IDLE, outs=0, out_valid=0. No done pulse.
  - abort in IDLE: no effect. abort and load_valid together in IDLE: the load is accepted.
- abort on the final-bit cycle: the final bit is still driven that cycle, but done is suppressed (abort wins).
- len==1: single-bit pattern. done is asserted in the first SHIFT cycle when rep==0.
- load_rep at all-ones: 2^REP_W total sends, with no overflow or wrap.

Test Plan:
- Basic send (WIDTH=8): reset, then load data=8'h0B, len=4, rep=0 → outs=1,0,1,1 on 4 consecutive cycles after accept, out_valid=1 throughout, done on the 4th, load_ready returns high the next cycle. Check against the detector FSM: outs goes to its `ins`, and it flags the 1011 sequence.
- Repeat with gap (IDLE_GAP=2): data=4'b1011, len=4, rep=2 → 1011,00,1011,00,1011. out_valid low exactly during the gaps. 16 cycles total, done on cycle 16.
- Length clamp: len=0, data=8'hA5 → 8 bits 1,0,1,0,0,1,0,1. Repeat with len=9 → same result.
- Busy/abort: during a frame, pulse load_valid (no accept, load_ready=0). Then assert abort after bit 2 → out_valid/outs=0 next cycle, no done, IDLE.
- Async reset: drop reset_n mid-SHIFT between clock edges → outs, out_valid and busy go 0 immediately. After release, a new load behaves as in the basic-send scenario.
- Back-to-back IDLE_GAP=0, rep=1, len=1, data=1 → outs=1,1 on two consecutive cycles, done on the second.
